// File: rtl/actor_trigger_sequencer_pkg.sv
// Shared trigger types: controller states, HLS actor return codes and helpers.
package TriggerTypes;

    localparam int TRIGGER_MAX_SLEEP_LIMIT = 255;

    typedef enum logic [1:0] {
        STAND_BY     = 2'd0,
        TRY_LAUNCH   = 2'd1,
        LAUNCH       = 2'd2,
        CHECK_RETURN = 2'd3
    } state_t;

    typedef enum logic [31:0] {
        IDLE           = 32'd0,
        EXECUTED       = 32'd1,
        WAIT_GAURD     = 32'd2,
        WAIT_INPUT     = 32'd3,
        WAIT_OUTPUT    = 32'd4,
        WAIT_PREDICATE = 32'd5
    } return_t;

    // Only EXECUTED counts as progress; IDLE and unknown codes are treated as a wait.
    function automatic logic is_wait(input return_t ret);
        logic w;
        case (ret)
            EXECUTED:       w = 1'b0;
            WAIT_GAURD:     w = 1'b1;
            WAIT_INPUT:     w = 1'b1;
            WAIT_OUTPUT:    w = 1'b1;
            WAIT_PREDICATE: w = 1'b1;
            IDLE:           w = 1'b1;
            default:        w = 1'b1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/actor_trigger_sequencer.sv
// Per-actor trigger: relaunches an HLS actor until it has waited SLEEP_LIMIT times
// in a row and the whole network agrees to sleep, then reports done.
module actor_trigger_sequencer
    import TriggerTypes::*;
#(
    parameter int SLEEP_LIMIT = 4,
    parameter int CNT_W       = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             actor_start,
    input  logic             actor_idle,
    input  logic             actor_done,
    input  logic [31:0]      actor_return,
    input  logic             all_sleep,
    output logic             sleep,
    output logic [CNT_W-1:0] exec_count
);

    localparam int WAIT_W = $clog2(SLEEP_LIMIT + 1);
    localparam logic [WAIT_W-1:0] LIMIT_W = WAIT_W'(SLEEP_LIMIT);

    generate
        if (SLEEP_LIMIT < 1 || SLEEP_LIMIT > TRIGGER_MAX_SLEEP_LIMIT) begin : g_bad_limit
            $error("actor_trigger_sequencer: SLEEP_LIMIT out of range 1..255");
        end
    endgenerate

    state_t            state_q,      state_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic [CNT_W-1:0]  exec_count_q, exec_count_d;
    logic              sleep_q,      sleep_d;
    logic              done_q,       done_d;

    // Completion decision, shared by the LAUNCH and CHECK_RETURN cycles
    state_t            dec_state_s;
    logic [WAIT_W-1:0] dec_wait_s;
    logic [CNT_W-1:0]  dec_exec_s;
    logic              dec_sleep_s;
    logic              dec_done_s;
    logic [WAIT_W-1:0] wait_inc_s;

    // Decide what a finished firing means for the wait counter, sleep and next state
    always_comb begin
        dec_state_s = STAND_BY;
        dec_wait_s  = wait_cnt_q;
        dec_exec_s  = exec_count_q;
        dec_sleep_s = sleep_q;
        dec_done_s  = 1'b0;
        wait_inc_s  = (wait_cnt_q == LIMIT_W) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        case (is_wait(return_t'(actor_return)))
            1'b0: begin
                dec_state_s = LAUNCH;
                dec_wait_s  = {WAIT_W{1'b0}};
                dec_sleep_s = 1'b0;
                dec_exec_s  = exec_count_q + CNT_W'(1);
            end
            1'b1: begin
                // Finish needs sleep from an earlier firing, not the one just counted
                if (sleep_q && all_sleep) begin
                    dec_state_s = STAND_BY;
                    dec_wait_s  = {WAIT_W{1'b0}};
                    dec_sleep_s = 1'b0;
                    dec_done_s  = 1'b1;
                end else begin
                    dec_state_s = LAUNCH;
                    dec_wait_s  = wait_inc_s;
                    dec_sleep_s = (wait_inc_s == LIMIT_W);
                end
            end
            default: begin
                dec_state_s = STAND_BY;
            end
        endcase
    end

    // Next-state logic for the launch handshake
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        exec_count_d = exec_count_q;
        sleep_d      = sleep_q;
        done_d       = 1'b0;
        case (state_q)
            STAND_BY: begin
                if (ap_start) begin
                    state_d      = TRY_LAUNCH;
                    wait_cnt_d   = {WAIT_W{1'b0}};
                    exec_count_d = {CNT_W{1'b0}};
                    sleep_d      = 1'b0;
                end else begin
                    state_d = STAND_BY;
                end
            end
            TRY_LAUNCH: begin
                if (actor_idle) begin
                    state_d = LAUNCH;
                end else begin
                    state_d = TRY_LAUNCH;
                end
            end
            LAUNCH, CHECK_RETURN: begin
                if (actor_done) begin
                    state_d      = dec_state_s;
                    wait_cnt_d   = dec_wait_s;
                    exec_count_d = dec_exec_s;
                    sleep_d      = dec_sleep_s;
                    done_d       = dec_done_s;
                end else begin
                    state_d = CHECK_RETURN;
                end
            end
            default: begin
                state_d = STAND_BY;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= STAND_BY;
            wait_cnt_q   <= {WAIT_W{1'b0}};
            exec_count_q <= {CNT_W{1'b0}};
            sleep_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            exec_count_q <= exec_count_d;
            sleep_q      <= sleep_d;
            done_q       <= done_d;
        end
    end

    assign ap_done     = done_q;
    assign ap_ready    = done_q;
    assign ap_idle     = (state_q == STAND_BY);
    assign actor_start = (state_q == LAUNCH);
    assign sleep       = sleep_q;
    assign exec_count  = exec_count_q;

endmodule

// File: tb/tb_actor_trigger_sequencer.sv
// Directed bench for actor_trigger_sequencer: firing table plus hand-built corner sequences.
module tb_actor_trigger_sequencer;
    import TriggerTypes::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic        actor_start;
    logic        actor_idle;
    logic        actor_done;
    logic [31:0] actor_return;
    logic        all_sleep;
    logic        sleep;
    logic [31:0] exec_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        start;
        logic [31:0] ret;
        logic        as;
        int          dly;
        logic        e_sleep;
        int          e_exec;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    always #5 ap_clk = ~ap_clk;

    actor_trigger_sequencer #(.SLEEP_LIMIT(4), .CNT_W(32)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .actor_start (actor_start),
        .actor_idle  (actor_idle),
        .actor_done  (actor_done),
        .actor_return(actor_return),
        .all_sleep   (all_sleep),
        .sleep       (sleep),
        .exec_count  (exec_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [31:0] r, input logic as, input int d,
                       input logic es, input int ee, input logic ed);
        vec_t v;
        v.start = st; v.ret = r; v.as = as; v.dly = d;
        v.e_sleep = es; v.e_exec = ee; v.e_done = ed;
        vecs.push_back(v);
    endtask

    // Called at a negedge with the DUT in LAUNCH; ends at the negedge after the decision edge.
    task automatic fire(input string tag, input logic [31:0] r, input logic as, input int d,
                        input logic es, input int ee, input logic ed);
        chk({tag, ".launch"}, {31'd0, actor_start}, 32'd1);
        for (int i = 0; i < d; i++) begin
            actor_done = 1'b0;
            @(negedge ap_clk);
            chk({tag, ".wait_start"}, {31'd0, actor_start}, 32'd0);
        end
        actor_done   = 1'b1;
        actor_return = r;
        all_sleep    = as;
        @(negedge ap_clk);
        actor_done   = 1'b0;
        actor_return = 32'd1;
        all_sleep    = ~as;
        chk({tag, ".sleep"},       {31'd0, sleep},       {31'd0, es});
        chk({tag, ".exec_count"},  exec_count,           ee);
        chk({tag, ".ap_done"},     {31'd0, ap_done},     {31'd0, ed});
        chk({tag, ".ap_ready"},    {31'd0, ap_ready},    {31'd0, ed});
        chk({tag, ".ap_idle"},     {31'd0, ap_idle},     {31'd0, ed});
        chk({tag, ".actor_start"}, {31'd0, actor_start}, {31'd0, ~ed});
    endtask

    task automatic launch_from_idle(input string tag);
        actor_done = 1'b1;
        @(negedge ap_clk);
        actor_done = 1'b0;
        chk({tag, ".idle_done_ignored"}, {30'd0, ap_done, ap_idle}, 32'd1);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        chk({tag, ".try_launch"}, {30'd0, ap_idle, actor_start}, 32'd0);
        @(negedge ap_clk);
        chk({tag, ".latency2"}, {31'd0, actor_start}, 32'd1);
        chk({tag, ".start_clear"}, exec_count, 32'd0);
        chk({tag, ".start_sleep"}, {31'd0, sleep}, 32'd0);
    endtask

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; actor_idle = 1'b1; actor_done = 1'b0;
        actor_return = 32'd0; all_sleep = 1'b0;

        // Three EXECUTED, four WAIT_INPUT raising sleep, fifth WAIT finishes
        add(1'b1, EXECUTED,   1'b0, 0, 1'b0, 1, 1'b0);
        add(1'b0, EXECUTED,   1'b0, 5, 1'b0, 2, 1'b0);
        add(1'b0, EXECUTED,   1'b0, 0, 1'b0, 3, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 3, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 5, 1'b0, 3, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 3, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 2, 1'b1, 3, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 3, 1'b1);
        // Every WAIT flavour counts; all_sleep=0 keeps relaunching while asleep
        add(1'b1, WAIT_PREDICATE, 1'b0, 0, 1'b0, 0, 1'b0);
        add(1'b0, WAIT_OUTPUT,    1'b0, 5, 1'b0, 0, 1'b0);
        add(1'b0, WAIT_GAURD,     1'b0, 0, 1'b0, 0, 1'b0);
        add(1'b0, IDLE,           1'b0, 1, 1'b1, 0, 1'b0);
        for (int i = 0; i < 10; i++) add(1'b0, WAIT_INPUT, 1'b0, (i % 2) * 5, 1'b1, 0, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 0, 1'b1);
        // EXECUTED between WAIT runs resets the count, so sleep stays low
        add(1'b1, WAIT_INPUT, 1'b1, 0, 1'b0, 0, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 0, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 0, 1'b0);
        add(1'b0, EXECUTED,   1'b1, 5, 1'b0, 1, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 1, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 5, 1'b0, 1, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b0, 1, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 0, 1'b1, 1, 1'b0);
        add(1'b0, WAIT_INPUT, 1'b1, 5, 1'b0, 1, 1'b1);

        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("reset.idle_ready_done", {29'd0, ap_idle, ap_ready, ap_done}, 32'd4);
        chk("reset.start_sleep", {30'd0, actor_start, sleep}, 32'd0);
        chk("reset.exec_count", exec_count, 32'd0);
        ap_rst_n = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].start) launch_from_idle($sformatf("v%0d", k));
            fire($sformatf("v%0d", k), vecs[k].ret, vecs[k].as, vecs[k].dly,
                 vecs[k].e_sleep, vecs[k].e_exec, vecs[k].e_done);
        end

        // actor_idle gates launch; actor_done in TRY_LAUNCH ignored
        @(negedge ap_clk);
        actor_idle = 1'b0;
        ap_start   = 1'b1;
        @(negedge ap_clk);
        ap_start   = 1'b0;
        actor_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            chk("gate.hold", {30'd0, ap_idle, actor_start}, 32'd0);
        end
        actor_done = 1'b0;
        actor_idle = 1'b1;
        @(negedge ap_clk);
        fire("gate.e", EXECUTED, 1'b0, 0, 1'b0, 1, 1'b0);
        fire("gate.w1", WAIT_INPUT, 1'b0, 0, 1'b0, 1, 1'b0);
        fire("gate.w2", WAIT_INPUT, 1'b0, 0, 1'b0, 1, 1'b0);
        fire("gate.w3", WAIT_INPUT, 1'b0, 0, 1'b0, 1, 1'b0);
        fire("gate.w4", WAIT_INPUT, 1'b0, 0, 1'b1, 1, 1'b0);

        // ap_start ignored in CHECK_RETURN, then reset abandons the firing
        actor_done = 1'b0;
        ap_start   = 1'b1;
        @(negedge ap_clk);
        chk("busy.check_return", {31'd0, actor_start}, 32'd0);
        chk("busy.exec_kept", exec_count, 32'd1);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        ap_start = 1'b0;
        chk("rst.idle", {31'd0, ap_idle}, 32'd1);
        chk("rst.exec_count", exec_count, 32'd0);
        chk("rst.sleep_start_done", {29'd0, sleep, actor_start, ap_done}, 32'd0);
        @(negedge ap_clk);
        chk("rst.stays_idle", {31'd0, ap_idle}, 32'd1);

        // ap_start held across ap_done with an undefined return code
        ap_start = 1'b1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        fire("b2b.w1", 32'h7, 1'b1, 0, 1'b0, 0, 1'b0);
        fire("b2b.w2", 32'h7, 1'b1, 3, 1'b0, 0, 1'b0);
        fire("b2b.w3", 32'h7, 1'b1, 0, 1'b0, 0, 1'b0);
        fire("b2b.w4", 32'h7, 1'b1, 0, 1'b1, 0, 1'b0);
        fire("b2b.fin", 32'h7, 1'b1, 0, 1'b0, 0, 1'b1);
        @(negedge ap_clk);
        chk("b2b.restart", {30'd0, ap_idle, ap_done}, 32'd0);
        ap_start = 1'b0;
        @(negedge ap_clk);
        fire("b2b.e", EXECUTED, 1'b0, 0, 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
